// File: rtl/ai_ctrl_pkg.sv
// Shared types and constants for the AI turn controller: FSM state codes,
// action codes and the item-action classifier.
package ai_ctrl_pkg;

    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t StIdle   = 3'd0;
    localparam ctrl_state_t StStart  = 3'd1;
    localparam ctrl_state_t StWait   = 3'd2;
    localparam ctrl_state_t StIssue  = 3'd3;
    localparam ctrl_state_t StSettle = 3'd4;

    typedef logic [3:0] action_t;

    localparam action_t ACT_SHOOT_ENEMY = 4'd0;
    localparam action_t ACT_SHOOT_SELF  = 4'd1;
    localparam action_t ACT_MAGNIFIER   = 4'd2;
    localparam action_t ACT_CIGARETTE   = 4'd3;
    localparam action_t ACT_BEER        = 4'd4;
    localparam action_t ACT_HANDCUFFS   = 4'd5;
    localparam action_t ACT_SAW         = 4'd6;
    localparam action_t ACT_PHONE       = 4'd7;
    localparam action_t ACT_REVERSE     = 4'd8;
    localparam action_t ACT_END_ITEM    = 4'd9;
    localparam action_t ACT_NONE        = 4'd15;

    function automatic logic is_item_action(action_t a);
        return (a >= ACT_MAGNIFIER) && (a <= ACT_REVERSE);
    endfunction

endpackage

// File: rtl/ai_turn_controller_if.sv
// Inference-engine and game-engine handshake signals of the AI turn controller.
// master = controller side, slave = MLP / mask_argmax / game engine side.
interface ai_turn_controller_if;
    import ai_ctrl_pkg::*;

    logic    infer_start;
    logic    infer_clear;
    logic    inference_done;
    action_t action;
    logic    act_valid;
    action_t act;
    logic    act_ready;

    modport master (
        output infer_start, infer_clear, act_valid, act,
        input  inference_done, action, act_ready
    );

    modport slave (
        input  infer_start, infer_clear, act_valid, act,
        output inference_done, action, act_ready
    );

endinterface

// File: rtl/ai_wait_timer.sv
// Loadable down-counter that saturates at zero; expired_o is high while the count is zero.
module ai_wait_timer #(
    parameter int unsigned Width = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ai_turn_controller.sv
// Sequences the AI turn around MLP inference: start, wait/timeout, issue, settle.
// Optional action history output enabled by AI_ACTION_LOG_EN.
module ai_turn_controller
    import ai_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ITEMS   = 4,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned SETTLE_CYC  = 4,
    localparam int unsigned ItemsW     = $clog2(MAX_ITEMS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_turn_req,
    input  logic                  i_abort,
    input  logic                  i_phase_shoot,
    ai_turn_controller_if.master  bus,
    output logic                  o_busy,
    output logic [ItemsW-1:0]     o_items_used,
    output logic                  o_timeout_err
`ifdef AI_ACTION_LOG_EN
    ,
    output logic [31:0]           o_act_hist
`endif
);

    localparam int unsigned TimerMax = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    ctrl_state_t       state_q, state_d;
    action_t           act_q, act_d;
    logic [ItemsW-1:0] items_q, items_d;
    logic              err_q, err_d;

    logic              tmr_load, tmr_dec, tmr_expired;
    logic [TimerW-1:0] tmr_val;
    logic              infer_start, infer_clear;
    action_t           fallback;

    assign fallback = i_phase_shoot ? ACT_SHOOT_ENEMY : ACT_END_ITEM;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        items_d     = items_q;
        err_d       = err_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        infer_start = 1'b0;
        infer_clear = 1'b0;

        if (i_abort) begin
            // Release the MLP if it was mid-inference so the next turn starts clean.
            state_d     = StIdle;
            infer_clear = (state_q == StWait);
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_turn_req) begin
                        state_d = StStart;
                        items_d = '0;
                        err_d   = 1'b0;
                    end
                end
                StStart: begin
                    if (!i_phase_shoot && (items_q == ItemsW'(MAX_ITEMS))) begin
                        act_d   = ACT_END_ITEM;
                        state_d = StIssue;
                    end else begin
                        infer_start = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_val     = TimerW'(TIMEOUT_CYC - 1);
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    tmr_dec = 1'b1;
                    if (bus.inference_done) begin
                        infer_clear = 1'b1;
                        state_d     = StIssue;
                        if (bus.action <= ACT_END_ITEM) begin
                            act_d = bus.action;
                        end else begin
                            act_d = fallback;
                            err_d = 1'b1;
                        end
                    end else if (tmr_expired) begin
                        infer_clear = 1'b1;
                        state_d     = StIssue;
                        act_d       = fallback;
                        err_d       = 1'b1;
                    end
                end
                StIssue: begin
                    if (bus.act_ready) begin
                        if (is_item_action(act_q) || (act_q == ACT_END_ITEM)) begin
                            if (is_item_action(act_q) && (items_q < ItemsW'(MAX_ITEMS))) begin
                                items_d = items_q + ItemsW'(1);
                            end
                            tmr_load = 1'b1;
                            tmr_val  = TimerW'(SETTLE_CYC - 1);
                            state_d  = StSettle;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StSettle: begin
                    if (tmr_expired) begin
                        state_d = StStart;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            act_q   <= '0;
            items_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            items_q <= items_d;
            err_q   <= err_d;
        end
    end

    ai_wait_timer #(
        .Width (TimerW)
    ) u_wait_timer (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_expired)
    );

    assign bus.infer_start = infer_start;
    assign bus.infer_clear = infer_clear;
    // Gating with abort keeps the engine from seeing a handshake on an aborted turn.
    assign bus.act_valid   = (state_q == StIssue) && !i_abort;
    assign bus.act         = act_q;
    assign o_busy          = (state_q != StIdle);
    assign o_items_used    = items_q;
    assign o_timeout_err   = err_q;

`ifdef AI_ACTION_LOG_EN
    logic [31:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if ((state_q == StIdle) && i_turn_req && !i_abort) begin
            hist_d = '1;
        end else if (bus.act_valid && bus.act_ready) begin
            hist_d = {hist_q[27:0], act_q};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign o_act_hist = hist_q;
`endif

endmodule

// File: tb/tb_ai_turn_controller.sv
// Directed bench for ai_turn_controller: default instance plus a MAX_ITEMS=2 instance
// for the item-cap scenario. Inputs change on negedge, outputs sampled 1ns later.
module tb_ai_turn_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       turn_req, abort, phase_shoot, done, ready;
    logic [3:0] action;
    logic       sel_b;

    int errors = 0;
    int checks = 0;
    int n_starts = 0;

    ai_turn_controller_if bus_a ();
    ai_turn_controller_if bus_b ();

    logic       busy_a, err_a, busy_b, err_b;
    logic [2:0] items_a;
    logic [1:0] items_b;
`ifdef AI_ACTION_LOG_EN
    logic [31:0] hist_a, hist_b;
`endif

    assign bus_a.inference_done = done;
    assign bus_a.action         = action;
    assign bus_a.act_ready      = ready;
    assign bus_b.inference_done = done;
    assign bus_b.action         = action;
    assign bus_b.act_ready      = ready;

    ai_turn_controller u_dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_turn_req    (turn_req),
        .i_abort       (abort),
        .i_phase_shoot (phase_shoot),
        .bus           (bus_a),
        .o_busy        (busy_a),
        .o_items_used  (items_a),
        .o_timeout_err (err_a)
`ifdef AI_ACTION_LOG_EN
        ,
        .o_act_hist    (hist_a)
`endif
    );

    ai_turn_controller #(
        .MAX_ITEMS (2)
    ) u_dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_turn_req    (turn_req),
        .i_abort       (abort),
        .i_phase_shoot (phase_shoot),
        .bus           (bus_b),
        .o_busy        (busy_b),
        .o_items_used  (items_b),
        .o_timeout_err (err_b)
`ifdef AI_ACTION_LOG_EN
        ,
        .o_act_hist    (hist_b)
`endif
    );

    always #5 clk = ~clk;

    logic       obs_start, obs_clear, obs_valid, obs_busy, obs_err;
    logic [3:0] obs_act, obs_items;

    always_comb begin
        if (sel_b) begin
            obs_start = bus_b.infer_start;
            obs_clear = bus_b.infer_clear;
            obs_valid = bus_b.act_valid;
            obs_act   = bus_b.act;
            obs_busy  = busy_b;
            obs_err   = err_b;
            obs_items = {2'b00, items_b};
        end else begin
            obs_start = bus_a.infer_start;
            obs_clear = bus_a.infer_clear;
            obs_valid = bus_a.act_valid;
            obs_act   = bus_a.act;
            obs_busy  = busy_a;
            obs_err   = err_a;
            obs_items = {1'b0, items_a};
        end
    end

    always @(negedge clk) begin
        #2;
        if (obs_start) n_starts++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic obs_sig(input int which);
        case (which)
            0:       return obs_start;
            1:       return obs_valid;
            default: return obs_clear;
        endcase
    endfunction

    // Returns the number of cycles until the selected output is seen (0 = this cycle).
    task automatic wait_for(input int which, input int limit, input string tag, output int n);
        n = 0;
        while (!obs_sig(which) && (n < limit)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_seen"}, {31'd0, obs_sig(which)}, 32'd1);
    endtask

    task automatic do_infer(input logic [3:0] a, input logic [3:0] exp_act, input int exp_gap,
                            input string tag);
        int n;
        wait_for(0, 100, tag, n);
        check_eq({tag, "_gap"}, n, exp_gap);
        @(negedge clk);
        done = 1'b1;
        action = a;
        #1;
        check_eq({tag, "_clear"}, {31'd0, obs_clear}, 32'd1);
        @(negedge clk);
        done = 1'b0;
        action = 4'hF;
        #1;
        check_eq({tag, "_valid"}, {31'd0, obs_valid}, 32'd1);
        check_eq({tag, "_act"}, {28'd0, obs_act}, {28'd0, exp_act});
    endtask

    task automatic start_turn();
        @(negedge clk);
        turn_req = 1'b1;
        @(negedge clk);
        turn_req = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int base;
        rst_n = 1'b0;
        turn_req = 1'b0;
        abort = 1'b0;
        phase_shoot = 1'b0;
        done = 1'b0;
        ready = 1'b0;
        action = 4'hF;
        sel_b = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check_eq("rst_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("rst_valid", {31'd0, obs_valid}, 32'd0);
        check_eq("rst_act", {28'd0, obs_act}, 32'd0);
        check_eq("rst_items", {28'd0, obs_items}, 32'd0);
        check_eq("rst_err", {31'd0, obs_err}, 32'd0);
        check_eq("rst_start", {31'd0, obs_start}, 32'd0);
`ifdef AI_ACTION_LOG_EN
        check_eq("rst_hist", hist_a, 32'hFFFF_FFFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Shoot turn, done 20 cycles after start
        phase_shoot = 1'b1;
        ready = 1'b1;
        base = n_starts;
        @(negedge clk);
        turn_req = 1'b1;
        #1;
        check_eq("sh_idle_busy", {31'd0, obs_busy}, 32'd0);
        @(negedge clk);
        turn_req = 1'b0;
        #1;
        check_eq("sh_start", {31'd0, obs_start}, 32'd1);
        check_eq("sh_busy", {31'd0, obs_busy}, 32'd1);
        @(negedge clk);
        #1;
        check_eq("sh_start_1cyc", {31'd0, obs_start}, 32'd0);
        repeat (18) @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        action = 4'd0;
        #1;
        check_eq("sh_clear", {31'd0, obs_clear}, 32'd1);
        check_eq("sh_valid_early", {31'd0, obs_valid}, 32'd0);
        @(negedge clk);
        done = 1'b0;
        action = 4'hF;
        #1;
        check_eq("sh_valid", {31'd0, obs_valid}, 32'd1);
        check_eq("sh_act", {28'd0, obs_act}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("sh_valid_drop", {31'd0, obs_valid}, 32'd0);
        check_eq("sh_idle", {31'd0, obs_busy}, 32'd0);
        check_eq("sh_items", {28'd0, obs_items}, 32'd0);
        check_eq("sh_nstart", n_starts - base, 32'd1);
`ifdef AI_ACTION_LOG_EN
        check_eq("sh_hist", hist_a, 32'hFFFF_FFF0);
`endif

        // Item loop: 5, 7, 9 then shoot-self
        phase_shoot = 1'b0;
        base = n_starts;
        start_turn();
        do_infer(4'd5, 4'd5, 0, "it1");
        do_infer(4'd7, 4'd7, 5, "it2");
        check_eq("it2_items", {28'd0, obs_items}, 32'd1);
        do_infer(4'd9, 4'd9, 5, "it3");
        check_eq("it3_items", {28'd0, obs_items}, 32'd2);
        phase_shoot = 1'b1;
        do_infer(4'd1, 4'd1, 5, "it4");
        check_eq("it4_items", {28'd0, obs_items}, 32'd2);
        @(negedge clk);
        #1;
        check_eq("it_end_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("it_end_items", {28'd0, obs_items}, 32'd2);
        check_eq("it_nstart", n_starts - base, 32'd4);
`ifdef AI_ACTION_LOG_EN
        check_eq("it_hist", hist_a, 32'hFFFF_5791);
`endif

        // Item cap on the MAX_ITEMS=2 instance
        sel_b = 1'b1;
        do_reset();
        phase_shoot = 1'b0;
        ready = 1'b1;
        base = n_starts;
        start_turn();
        do_infer(4'd3, 4'd3, 0, "cap1");
        do_infer(4'd4, 4'd4, 5, "cap2");
        action = 4'd6;
        @(negedge clk);
        #1;
        wait_for(1, 50, "cap_forced", n);
        check_eq("cap_forced_lat", n, 32'd5);
        check_eq("cap_forced_act", {28'd0, obs_act}, 32'd9);
        check_eq("cap_nstart", n_starts - base, 32'd2);
        check_eq("cap_items", {28'd0, obs_items}, 32'd2);
        phase_shoot = 1'b1;
        action = 4'hF;
        do_infer(4'd0, 4'd0, 5, "cap_end");
        @(negedge clk);
        #1;
        check_eq("cap_end_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("cap_end_nstart", n_starts - base, 32'd3);

        // Timeout with backpressure, then abort during ISSUE
        sel_b = 1'b0;
        do_reset();
        phase_shoot = 1'b0;
        ready = 1'b0;
        start_turn();
        check_eq("to_start", {31'd0, obs_start}, 32'd1);
        wait_for(2, 5000, "to_clear", n);
        check_eq("to_lat", n, 32'd4096);
        check_eq("to_valid_early", {31'd0, obs_valid}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("to_valid", {31'd0, obs_valid}, 32'd1);
        check_eq("to_act", {28'd0, obs_act}, 32'd9);
        check_eq("to_err", {31'd0, obs_err}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp_valid", {31'd0, obs_valid}, 32'd1);
            check_eq("bp_act", {28'd0, obs_act}, 32'd9);
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        check_eq("bp_hs_valid", {31'd0, obs_valid}, 32'd1);
        do_infer(4'd5, 4'd5, 5, "to_it");
        wait_for(0, 100, "ab_start", n);
        check_eq("ab_gap", n, 32'd5);
        check_eq("ab_items_pre", {28'd0, obs_items}, 32'd1);
        @(negedge clk);
        done = 1'b1;
        action = 4'd6;
        ready = 1'b0;
        #1;
        check_eq("ab_clear", {31'd0, obs_clear}, 32'd1);
        @(negedge clk);
        done = 1'b0;
        action = 4'hF;
        #1;
        check_eq("ab_valid", {31'd0, obs_valid}, 32'd1);
        check_eq("ab_act", {28'd0, obs_act}, 32'd6);
        @(negedge clk);
        abort = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("ab_valid_drop", {31'd0, obs_valid}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b0;
        #1;
        check_eq("ab_idle", {31'd0, obs_busy}, 32'd0);
        check_eq("ab_items", {28'd0, obs_items}, 32'd1);
        check_eq("ab_err_sticky", {31'd0, obs_err}, 32'd1);

        // Next turn clears sticky error; out-of-range action falls back
        ready = 1'b1;
        start_turn();
        check_eq("t2_start", {31'd0, obs_start}, 32'd1);
        check_eq("t2_err_clr", {31'd0, obs_err}, 32'd0);
        check_eq("t2_items_clr", {28'd0, obs_items}, 32'd0);
        @(negedge clk);
        done = 1'b1;
        action = 4'd12;
        #1;
        check_eq("bad_clear", {31'd0, obs_clear}, 32'd1);
        @(negedge clk);
        done = 1'b0;
        action = 4'hF;
        #1;
        check_eq("bad_valid", {31'd0, obs_valid}, 32'd1);
        check_eq("bad_act", {28'd0, obs_act}, 32'd9);
        check_eq("bad_err", {31'd0, obs_err}, 32'd1);
        wait_for(0, 100, "wab_start", n);
        check_eq("wab_gap", n, 32'd5);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check_eq("wab_clear", {31'd0, obs_clear}, 32'd1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_eq("wab_idle", {31'd0, obs_busy}, 32'd0);

        // Asynchronous reset while waiting for inference
        start_turn();
        @(negedge clk);
        #1;
        check_eq("ar_busy_pre", {31'd0, obs_busy}, 32'd1);
        check_eq("ar_act_pre", {28'd0, obs_act}, 32'd9);
        rst_n = 1'b0;
        #1;
        check_eq("ar_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("ar_valid", {31'd0, obs_valid}, 32'd0);
        check_eq("ar_act", {28'd0, obs_act}, 32'd0);
        check_eq("ar_items", {28'd0, obs_items}, 32'd0);
        check_eq("ar_err", {31'd0, obs_err}, 32'd0);
        check_eq("ar_start", {31'd0, obs_start}, 32'd0);
        check_eq("ar_clear", {31'd0, obs_clear}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
